refill_memory: RTL

//  Backing-store responder for the 2-way set-associative cache refill path. Accepts a

---
 rtl/refill_pkg.sv | 24 ++
 rtl/line_mem_array.sv | 38 +++
 rtl/refill_memory.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/refill_pkg.sv
// Shared types and sizes for the cache refill backing store.
package refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b11
  } state_t;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 6;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_IDX_W     = ADDR_W - 2;
  localparam int CNT_W          = 4;

  // Reset image: each word holds its own address.
  function automatic logic [WORD_W-1:0] preload_word(
    input logic [ADDR_W-1:0] a
  );
    return {{(WORD_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Word-write / line-read storage array with reset preload.
module line_mem_array
  import refill_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic [LINE_IDX_W-1:0] i_line,
  output logic [LINE_W-1:0]     o_line
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= preload_word(ADDR_W'(i));
      end
    end else if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Word 0 of the line sits in the most significant slot.
  always_comb begin
    o_line = {
      r_mem[{i_line, 2'b00}],
      r_mem[{i_line, 2'b01}],
      r_mem[{i_line, 2'b10}],
      r_mem[{i_line, 2'b11}]
    };
  end

endmodule

// File: rtl/refill_memory.sv
// Fixed-latency line responder for the cache refill path.
// Optional last-line buffer: define LAST_LINE_BUF_EN.
module refill_memory
  import refill_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam bit               LAT_ONE  = (LATENCY == 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [LINE_IDX_W-1:0] r_line;
  logic [LINE_W-1:0]     r_rdata;
  logic                  r_rvalid;
  logic                  r_busy;

  logic [LINE_IDX_W-1:0] w_rd_line;
  logic [LINE_W-1:0]     w_mem_line;
  logic                  w_accept;
  logic                  w_hit;
  logic [LINE_W-1:0]     w_buf_data;
  logic                  w_load;
  logic                  w_unused_ok;

  assign w_unused_ok = ^raddr[1:0];

  // In IDLE the array is addressed straight from the request.
  assign w_rd_line = (r_state == ST_IDLE) ? raddr[5:2] : r_line;
  assign w_accept  = (r_state == ST_IDLE) && req;

  assign w_load = (r_state == ST_WAIT && r_cnt == CNT_W'(1))
               || (w_accept && !w_hit && LAT_ONE);

  line_mem_array #(
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (wr_en),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_line  (w_rd_line),
    .o_line  (w_mem_line)
  );

`ifdef LAST_LINE_BUF_EN
  logic                  r_buf_vld;
  logic [LINE_IDX_W-1:0] r_buf_idx;
  logic [LINE_W-1:0]     r_buf_data;
  logic [LINE_IDX_W-1:0] w_buf_idx_nxt;

  assign w_buf_idx_nxt = w_load ? w_rd_line : r_buf_idx;
  assign w_hit         = r_buf_vld && (raddr[5:2] == r_buf_idx);
  assign w_buf_data    = r_buf_data;

  // A write landing on the buffered line always wins over a refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_vld  <= 1'b0;
      r_buf_idx  <= '0;
      r_buf_data <= '0;
    end else begin
      if (w_load) begin
        r_buf_vld  <= 1'b1;
        r_buf_idx  <= w_rd_line;
        r_buf_data <= w_mem_line;
      end
      if (wr_en && waddr[5:2] == w_buf_idx_nxt) begin
        r_buf_vld <= 1'b0;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_buf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_line   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_line <= raddr[5:2];
            r_cnt  <= CNT_INIT;
            r_busy <= 1'b1;
            if (w_hit) begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= w_buf_data;
            end else if (LAT_ONE) begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= w_mem_line;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= ST_RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= w_mem_line;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_rvalid <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;

endmodule
